regfile_scb: RTL and testbench

Parametrised multi-read-port register file with write-through bypass, optional hardwired zero register, and an integrated per-register scoreboard that tracks pending writes. It generalises the fixed 32x32, two-read-port register file to configurable width, depth and read-port count. It sits between decode (claims and reads) and writeback (writes), letting the issue stage detect RAW hazards without a separate scoreboard block.

---
 rtl/regfile_pkg.sv | 14 +
 rtl/regfile_scoreboard.sv | 54 +++++
 rtl/regfile_scb.sv | 88 ++++++++
 tb/tb_regfile_scb.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults and packed-port slicing helper for the register file,
// decode and writeback.
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_NUM_RD = 2;

  // Low bit index of port `port` inside a packed bus of `width`-bit fields.
  function automatic int unsigned port_lo(input int unsigned port, input int unsigned width);
    return port * width;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per register plus an incrementally
// maintained population count.
module regfile_scoreboard #(
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic                     claim_en,
  input  logic [ADDR_W-1:0]        claim_addr,
  output logic [(1<<ADDR_W)-1:0]   busy_o,
  output logic [ADDR_W:0]          cnt_o
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam bit ZR    = (ZERO_REG != 0);

  logic [DEPTH-1:0] busy_q, busy_d;
  logic [ADDR_W:0]  cnt_q, cnt_d;
  logic             claim_ok, wr_ok, inc, dec;

  assign claim_ok = claim_en && !(ZR && (claim_addr == '0));
  assign wr_ok    = wr_en    && !(ZR && (wr_addr == '0));

  // A same-cycle claim overrides the retiring write: the new producer owns the reg.
  always_comb begin
    busy_d = busy_q;
    if (wr_ok)    busy_d[wr_addr]    = 1'b0;
    if (claim_ok) busy_d[claim_addr] = 1'b1;
  end

  assign inc = claim_ok && !busy_q[claim_addr];
  assign dec = wr_ok && busy_q[wr_addr] && !(claim_ok && (claim_addr == wr_addr));

  always_comb begin
    cnt_d = cnt_q + (ADDR_W+1)'(inc) - (ADDR_W+1)'(dec);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_o = busy_q;
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/regfile_scb.sv
// Multi-read-port register file with write-through bypass, optional zero
// register and an integrated pending-write scoreboard.
module regfile_scb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = DEF_NUM_RD,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     claim_en,
  input  logic [ADDR_W-1:0]        claim_addr,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  output logic [ADDR_W:0]          busy_cnt
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam bit ZR    = (ZERO_REG != 0);
  localparam bit BYP   = (BYPASS != 0);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  busy_vec;
  logic [ADDR_W:0]   cnt;

  regfile_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_scb (
    .clk        (clk),
    .reset_n    (reset_n),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .claim_en   (claim_en),
    .claim_addr (claim_addr),
    .busy_o     (busy_vec),
    .cnt_o      (cnt)
  );

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_reg
    localparam bit WRITABLE = !(ZR && (gi == 0));
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        mem_q[gi] <= '0;
      end else if (WRITABLE && wr_en && (wr_addr == ADDR_W'(gi))) begin
        mem_q[gi] <= wr_data;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              is_zero, hit;
    logic [DATA_W-1:0] data;
    logic              busy;

    assign ra      = rd_addr[port_lo(gi, ADDR_W) +: ADDR_W];
    assign is_zero = ZR && (ra == '0);
    assign hit     = BYP && wr_en && (wr_addr == ra) && !is_zero;

    // Outputs are forced to 0 while reset is held so in-flight traffic cannot leak through.
    always_comb begin
      data = mem_q[ra];
      busy = busy_vec[ra];
      if (hit) begin
        data = wr_data;
        busy = 1'b0;
      end
      if (is_zero || !reset_n) begin
        data = '0;
        busy = 1'b0;
      end
    end

    assign rd_data[port_lo(gi, DATA_W) +: DATA_W] = data;
    assign rd_busy[gi] = busy;
  end

  assign busy_cnt = reset_n ? cnt : '0;

endmodule

// File: tb/tb_regfile_scb.sv
// Directed scoreboard bench for regfile_scb: stimulus queues expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_regfile_scb;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NUM_RD = 2;

  logic                     clk = 1'b0;
  logic                     reset_n = 1'b0;
  logic                     wr_en = 1'b0;
  logic [ADDR_W-1:0]        wr_addr = '0;
  logic [DATA_W-1:0]        wr_data = '0;
  logic                     claim_en = 1'b0;
  logic [ADDR_W-1:0]        claim_addr = '0;
  logic [NUM_RD*ADDR_W-1:0] rd_addr = '0;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic [ADDR_W:0]          busy_cnt;

  regfile_scb #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .ZERO_REG(1), .BYPASS(1)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .claim_en   (claim_en),
    .claim_addr (claim_addr),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_busy    (rd_busy),
    .busy_cnt   (busy_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string             name;
    logic [DATA_W-1:0] d0;
    logic [DATA_W-1:0] d1;
    logic [1:0]        busy;
    logic [ADDR_W:0]   cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Monitor: the DUT presents a fresh read result every cycle; compare at negedge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic ok;
      e  = exp_q.pop_front();
      ok = 1'b1;
      n_cmp++;
      if (rd_data[DATA_W-1:0] !== e.d0) begin
        n_bad++; ok = 1'b0;
        $display("FAIL %s rd_data0: got %h want %h", e.name, rd_data[DATA_W-1:0], e.d0);
      end
      n_cmp++;
      if (rd_data[2*DATA_W-1:DATA_W] !== e.d1) begin
        n_bad++; ok = 1'b0;
        $display("FAIL %s rd_data1: got %h want %h", e.name, rd_data[2*DATA_W-1:DATA_W], e.d1);
      end
      n_cmp++;
      if (rd_busy !== e.busy) begin
        n_bad++; ok = 1'b0;
        $display("FAIL %s rd_busy: got %b want %b", e.name, rd_busy, e.busy);
      end
      n_cmp++;
      if (busy_cnt !== e.cnt) begin
        n_bad++; ok = 1'b0;
        $display("FAIL %s busy_cnt: got %0d want %0d", e.name, busy_cnt, e.cnt);
      end
      if (ok) $display("chk %-12s d0=%h d1=%h busy=%b cnt=%0d ok", e.name, rd_data[DATA_W-1:0],
                       rd_data[2*DATA_W-1:DATA_W], rd_busy, busy_cnt);
    end
  end

  // One cycle of stimulus, applied just after the rising edge.
  task automatic cyc(input logic we, input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                     input logic ce, input logic [ADDR_W-1:0] ca,
                     input logic [ADDR_W-1:0] ra0, input logic [ADDR_W-1:0] ra1);
    @(posedge clk);
    #1;
    wr_en = we; wr_addr = wa; wr_data = wd;
    claim_en = ce; claim_addr = ca;
    rd_addr = {ra1, ra0};
  endtask

  task automatic expect_rd(input string name, input logic [DATA_W-1:0] d0, input logic [DATA_W-1:0] d1,
                           input logic b0, input logic b1, input int cnt);
    exp_t e;
    e.name = name; e.d0 = d0; e.d1 = d1; e.busy = {b1, b0}; e.cnt = (ADDR_W+1)'(cnt);
    exp_q.push_back(e);
  endtask

  initial begin
    // Reset held low with traffic: everything reads 0.
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, ADDR_W'($urandom_range(1, 31)), $urandom, 1'b1, ADDR_W'($urandom_range(1, 31)),
          ADDR_W'($urandom_range(0, 31)), ADDR_W'($urandom_range(0, 31)));
      expect_rd("rst_hold", '0, '0, 0, 0, 0);
    end
    // Release between edges, then scan every register.
    cyc(1'b0, '0, '0, 1'b0, '0, 5'd1, 5'd1);
    reset_n = 1'b1;
    expect_rd("post_rst", '0, '0, 0, 0, 0);
    for (int r = 2; r < 32; r++) begin
      cyc(1'b0, '0, '0, 1'b0, '0, ADDR_W'(r), ADDR_W'(33 - r));
      expect_rd("scan", '0, '0, 0, 0, 0);
    end

    // Write-through and registered read.
    cyc(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, 5'd5, 5'd5);
    expect_rd("wr_bypass", 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0);
    cyc(1'b0, '0, '0, 1'b0, '0, 5'd5, 5'd5);
    expect_rd("wr_read", 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0);

    // Zero register ignores write and claim.
    cyc(1'b1, 5'd0, 32'h12345678, 1'b1, 5'd0, 5'd0, 5'd0);
    expect_rd("zero_same", '0, '0, 0, 0, 0);
    cyc(1'b0, '0, '0, 1'b0, '0, 5'd0, 5'd5);
    expect_rd("zero_next", '0, 32'hDEADBEEF, 0, 0, 0);

    // Claims: no same-cycle forwarding, count follows one cycle later.
    cyc(1'b0, '0, '0, 1'b1, 5'd3, 5'd3, 5'd7);
    expect_rd("claim3", '0, '0, 0, 0, 0);
    cyc(1'b0, '0, '0, 1'b1, 5'd7, 5'd3, 5'd7);
    expect_rd("claim7", '0, '0, 1, 0, 1);
    cyc(1'b0, '0, '0, 1'b0, '0, 5'd3, 5'd7);
    expect_rd("busy2", '0, '0, 1, 1, 2);

    // Writeback clears busy.
    cyc(1'b1, 5'd3, 32'h11, 1'b0, '0, 5'd3, 5'd7);
    expect_rd("wb3_same", 32'h11, '0, 0, 1, 2);
    cyc(1'b0, '0, '0, 1'b0, '0, 5'd3, 5'd7);
    expect_rd("wb3_next", 32'h11, '0, 0, 1, 1);

    // Claim+write same register while busy: claim wins.
    cyc(1'b0, '0, '0, 1'b1, 5'd9, 5'd9, 5'd7);
    expect_rd("claim9", '0, '0, 0, 1, 1);
    cyc(1'b0, '0, '0, 1'b0, '0, 5'd9, 5'd7);
    expect_rd("busy9", '0, '0, 1, 1, 2);
    cyc(1'b1, 5'd9, 32'hA5A5A5A5, 1'b1, 5'd9, 5'd9, 5'd7);
    expect_rd("cw9_same", 32'hA5A5A5A5, '0, 0, 1, 2);
    cyc(1'b0, '0, '0, 1'b0, '0, 5'd9, 5'd7);
    expect_rd("cw9_next", 32'hA5A5A5A5, '0, 1, 1, 2);

    // Re-claim of a busy register, write to a non-busy register.
    cyc(1'b0, '0, '0, 1'b1, 5'd9, 5'd9, 5'd7);
    expect_rd("reclaim9", 32'hA5A5A5A5, '0, 1, 1, 2);
    cyc(1'b1, 5'd5, 32'h77, 1'b0, '0, 5'd5, 5'd9);
    expect_rd("wr_free5", 32'h77, 32'hA5A5A5A5, 0, 1, 2);
    cyc(1'b0, '0, '0, 1'b0, '0, 5'd5, 5'd9);
    expect_rd("rd5", 32'h77, 32'hA5A5A5A5, 0, 1, 2);

    // Claim+write of a non-busy register, then asynchronous reset mid-cycle.
    cyc(1'b1, 5'd4, 32'h55, 1'b1, 5'd4, 5'd4, 5'd9);
    expect_rd("cw4_same", 32'h55, 32'hA5A5A5A5, 0, 1, 2);
    cyc(1'b0, '0, '0, 1'b0, '0, 5'd4, 5'd9);
    expect_rd("cw4_next", 32'h55, 32'hA5A5A5A5, 1, 1, 3);
    cyc(1'b1, 5'd6, 32'hCAFE, 1'b1, 5'd6, 5'd4, 5'd9);
    reset_n = 1'b0;
    expect_rd("async_rst", '0, '0, 0, 0, 0);
    cyc(1'b0, '0, '0, 1'b0, '0, 5'd4, 5'd9);
    reset_n = 1'b1;
    expect_rd("rst_r4", '0, '0, 0, 0, 0);
    cyc(1'b0, '0, '0, 1'b0, '0, 5'd6, 5'd5);
    expect_rd("rst_r6", '0, '0, 0, 0, 0);

    // Bounded drain of the expectation queue.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
